// File: rtl/bus_width_resize_if.sv
// Ready/valid bus carrying both sides of a width converter: the input stream and the resized output stream.
// The master side drives input data and output backpressure; the slave side is the converter.
interface bus_width_resize_if #(
   parameter int SIZE_IN  = 32,
   parameter int SIZE_OUT = 8
);
   localparam int KEEP_W = (SIZE_OUT > SIZE_IN) ? SIZE_OUT / SIZE_IN : 1;

   logic                input_valid;
   logic                input_ready;
   logic [SIZE_IN-1:0]  data_in;
   logic                input_last;
   logic                output_valid;
   logic                output_ready;
   logic [SIZE_OUT-1:0] data_out;
   logic                output_last;
   logic [KEEP_W-1:0]   output_keep;

   modport master (
      output input_valid, data_in, input_last, output_ready,
      input  input_ready, output_valid, data_out, output_last, output_keep
   );

   modport slave (
      input  input_valid, data_in, input_last, output_ready,
      output input_ready, output_valid, data_out, output_last, output_keep
   );
endinterface

// File: rtl/bus_width_resize.sv
// Ready/valid width converter: serialises wide words into slices (downsize), packs narrow words
// into lanes with keep/last flush (upsize), or passes through a single register stage (equal).
module bus_width_resize #(
   parameter int SIZE_IN       = 32,
   parameter int SIZE_OUT      = 8,
   parameter bit LITTLE_ENDIAN = 1'b1
) (
   input logic              clk,
   input logic              rst,
   bus_width_resize_if.slave bus
);
   localparam int RATIO = (SIZE_IN > SIZE_OUT) ? SIZE_IN / SIZE_OUT : SIZE_OUT / SIZE_IN;
   localparam int PTR_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(RATIO - 1);

   genvar gi;

   generate
   if ((SIZE_IN % SIZE_OUT != 0) && (SIZE_OUT % SIZE_IN != 0)) begin : g_bad_ratio
      $error("bus_width_resize: SIZE_IN and SIZE_OUT must be multiples of one another");
   end

   if (SIZE_IN > SIZE_OUT) begin : g_down
      typedef enum logic {EMPTY, SERIAL} state_t;
      state_t              state_reg, state_next;
      logic [SIZE_IN-1:0]  word_reg, word_next;
      logic                last_reg, last_next;
      logic [PTR_W-1:0]    ptr_reg, ptr_next;
      logic                in_fire, out_fire;

      assign in_fire  = bus.input_valid && bus.input_ready;
      assign out_fire = bus.output_valid && bus.output_ready;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_reg <= EMPTY;
            word_reg  <= '0;
            last_reg  <= 1'b0;
            ptr_reg   <= '0;
         end else begin
            state_reg <= state_next;
            word_reg  <= word_next;
            last_reg  <= last_next;
            ptr_reg   <= ptr_next;
         end
      end

      // The word register shifts so the current slice always sits at a fixed position.
      always_comb begin
         state_next = state_reg;
         word_next  = word_reg;
         last_next  = last_reg;
         ptr_next   = ptr_reg;
         case (state_reg)
            EMPTY: begin
               if (in_fire) begin
                  state_next = SERIAL;
                  word_next  = bus.data_in;
                  last_next  = bus.input_last;
                  ptr_next   = '0;
               end
            end
            SERIAL: begin
               if (out_fire) begin
                  if (ptr_reg == LAST_IDX) begin
                     if (in_fire) begin
                        word_next = bus.data_in;
                        last_next = bus.input_last;
                        ptr_next  = '0;
                     end else begin
                        state_next = EMPTY;
                     end
                  end else begin
                     ptr_next  = ptr_reg + 1'b1;
                     word_next = LITTLE_ENDIAN ? (word_reg >> SIZE_OUT) : (word_reg << SIZE_OUT);
                  end
               end
            end
            default: state_next = EMPTY;
         endcase
      end

      always_comb begin
         bus.output_valid = (state_reg == SERIAL);
         bus.output_last  = (state_reg == SERIAL) && last_reg && (ptr_reg == LAST_IDX);
         bus.input_ready  = !rst && ((state_reg == EMPTY) ||
                                     ((ptr_reg == LAST_IDX) && bus.output_ready));
         bus.output_keep  = '1;
         bus.data_out     = LITTLE_ENDIAN ? word_reg[SIZE_OUT-1:0] : word_reg[SIZE_IN-1 -: SIZE_OUT];
      end

   end else if (SIZE_IN < SIZE_OUT) begin : g_up
      logic [SIZE_OUT-1:0] acc_reg, acc_next, acc_with;
      logic [RATIO-1:0]    lanes_reg, lanes_next, lanes_with;
      logic [PTR_W-1:0]    cnt_reg, cnt_next, lane_sel;
      logic                pending_reg, pending_next;
      logic [SIZE_OUT-1:0] data_reg, data_next;
      logic [RATIO-1:0]    keep_reg, keep_next;
      logic                last_reg, last_next;
      logic                valid_reg, valid_next;
      logic                in_fire, out_free;

      assign in_fire  = bus.input_valid && bus.input_ready;
      assign out_free = !valid_reg || bus.output_ready;
      assign lane_sel = LITTLE_ENDIAN ? cnt_reg : (LAST_IDX - cnt_reg);

      for (gi = 0; gi < RATIO; gi++) begin : g_lane
         assign acc_with[gi*SIZE_IN +: SIZE_IN] = (lane_sel == PTR_W'(gi)) ?
                                                  bus.data_in : acc_reg[gi*SIZE_IN +: SIZE_IN];
         assign lanes_with[gi] = lanes_reg[gi] || (lane_sel == PTR_W'(gi));
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            acc_reg     <= '0;
            lanes_reg   <= '0;
            cnt_reg     <= '0;
            pending_reg <= 1'b0;
            data_reg    <= '0;
            keep_reg    <= '0;
            last_reg    <= 1'b0;
            valid_reg   <= 1'b0;
         end else begin
            acc_reg     <= acc_next;
            lanes_reg   <= lanes_next;
            cnt_reg     <= cnt_next;
            pending_reg <= pending_next;
            data_reg    <= data_next;
            keep_reg    <= keep_next;
            last_reg    <= last_next;
            valid_reg   <= valid_next;
         end
      end

      // A short packet ending while the output is held parks in the accumulator (pending)
      // so ready never has to depend on input_valid/input_last.
      always_comb begin
         acc_next     = acc_reg;
         lanes_next   = lanes_reg;
         cnt_next     = cnt_reg;
         pending_next = pending_reg;
         data_next    = data_reg;
         keep_next    = keep_reg;
         last_next    = last_reg;
         valid_next   = valid_reg && !bus.output_ready;
         if (pending_reg) begin
            if (out_free) begin
               data_next    = acc_reg;
               keep_next    = lanes_reg;
               last_next    = 1'b1;
               valid_next   = 1'b1;
               acc_next     = '0;
               lanes_next   = '0;
               cnt_next     = '0;
               pending_next = 1'b0;
            end
         end else if (in_fire) begin
            if ((cnt_reg == LAST_IDX) || bus.input_last) begin
               if (out_free) begin
                  data_next  = acc_with;
                  keep_next  = lanes_with;
                  last_next  = bus.input_last;
                  valid_next = 1'b1;
                  acc_next   = '0;
                  lanes_next = '0;
                  cnt_next   = '0;
               end else begin
                  acc_next     = acc_with;
                  lanes_next   = lanes_with;
                  pending_next = 1'b1;
               end
            end else begin
               acc_next   = acc_with;
               lanes_next = lanes_with;
               cnt_next   = cnt_reg + 1'b1;
            end
         end
      end

      always_comb begin
         bus.output_valid = valid_reg;
         bus.data_out     = data_reg;
         bus.output_keep  = keep_reg;
         bus.output_last  = last_reg;
         bus.input_ready  = !rst && !pending_reg &&
                            (!valid_reg || bus.output_ready || (cnt_reg != LAST_IDX));
      end

   end else begin : g_equal
      logic [SIZE_IN-1:0] data_reg;
      logic               last_reg;
      logic               valid_reg;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            data_reg  <= '0;
            last_reg  <= 1'b0;
            valid_reg <= 1'b0;
         end else if (bus.input_valid && bus.input_ready) begin
            data_reg  <= bus.data_in;
            last_reg  <= bus.input_last;
            valid_reg <= 1'b1;
         end else if (bus.output_ready) begin
            valid_reg <= 1'b0;
         end
      end

      always_comb begin
         bus.output_valid = valid_reg;
         bus.data_out     = data_reg;
         bus.output_last  = last_reg;
         bus.output_keep  = '1;
         bus.input_ready  = !rst && (!valid_reg || bus.output_ready);
      end
   end
   endgenerate
endmodule
